// File: rtl/enc_stage_pipeline.sv
// -----------------------------------------------------------------------------
// enc_stage_pipeline
//
// Purpose:
//   Carries per-LCU side-info words down a DEPTH-stage pipeline that moves one
//   stage on each LCU boundary strobe. Each stage has a valid bit. A separate
//   rate-control counter counts the bitstream beats of the current LCU and
//   captures the total at each boundary.
//
// Parameters:
//   DATA_W : width of the side-info word per LCU (1..1024)
//   DEPTH  : number of pipeline stages (2..8)
//   CNT_W  : width of the per-LCU beat counter (4..32)
//
// Ports:
//   clk                 in   clock; all state changes on the rising edge
//   rst                 in   synchronous active-high reset
//   enc_done_i          in   LCU boundary strobe; shifts the pipeline
//   lcu_val_i           in   data_i is a real LCU (sampled with enc_done_i)
//   data_i              in   side-info word for the entering LCU
//   flush_i             in   clears all valid bits; wins over enc_done_i
//   bs_val_i            in   one bitstream beat this cycle
//   stage_data_o        out  stage k at [k*DATA_W +: DATA_W], stage 0 youngest
//   stage_val_o         out  bit k = stage k holds a valid LCU
//   occ_o               out  number of valid stages
//   retire_o            out  one-cycle pulse: a valid LCU left the last stage
//   rc_actual_bitnum_o  out  beat count of the last completed LCU
//   rc_sat_o            out  rc_actual_bitnum_o saturated
// -----------------------------------------------------------------------------
module enc_stage_pipeline #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enc_done_i,
    input  logic                      lcu_val_i,
    input  logic [DATA_W-1:0]         data_i,
    input  logic                      flush_i,
    input  logic                      bs_val_i,
    output logic [DEPTH*DATA_W-1:0]   stage_data_o,
    output logic [DEPTH-1:0]          stage_val_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o,
    output logic                      retire_o,
    output logic [CNT_W-1:0]          rc_actual_bitnum_o,
    output logic                      rc_sat_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Packed so that stage k lands at bits [k*DATA_W +: DATA_W] directly.
    logic [DEPTH-1:0][DATA_W-1:0] stage_q;
    logic [DEPTH-1:0]             val_q;
    logic                         retire_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         sat_q;
    logic [CNT_W-1:0]             rc_bits_q;
    logic                         rc_sat_q;

    // -------------------------------------------------------------------------
    // Stage pipeline
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and the shift chain moves exactly one stage per strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stage data registers are reset as well, not only the
            // valid bits, so a freshly reset pipeline shows all-zero data.
            stage_q  <= '0;
            val_q    <= '0;
            retire_q <= 1'b0;
        end else if (flush_i) begin
            // Flush drops validity only; data and the strobe's new word are
            // left alone / discarded.
            val_q    <= '0;
            retire_q <= 1'b0;
        end else if (enc_done_i) begin
            stage_q  <= {stage_q[DEPTH-2:0], data_i};
            val_q    <= {val_q[DEPTH-2:0], lcu_val_i};
            retire_q <= val_q[DEPTH-1];
        end else begin
            retire_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Rate-control beat counter; the capture on a strobe ignores flush_i.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            rc_bits_q <= '0;
            rc_sat_q  <= 1'b0;
        end else if (enc_done_i) begin
            rc_bits_q <= cnt_q;
            rc_sat_q  <= sat_q;
            // A beat coincident with the boundary belongs to the new LCU.
            cnt_q     <= {{(CNT_W-1){1'b0}}, bs_val_i};
            sat_q     <= 1'b0;
        end else if (bs_val_i) begin
            if (cnt_q == CNT_MAX) begin
                sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy: popcount of the valid bits, combinational so it never lags.
    // -------------------------------------------------------------------------
    logic [OCC_W-1:0] occ;

    // NOTE: occ gets a default before the loop so this block can never infer
    // a latch.
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(val_q[k]);
        end
    end

    assign stage_data_o       = stage_q;
    assign stage_val_o        = val_q;
    assign occ_o              = occ;
    assign retire_o           = retire_q;
    assign rc_actual_bitnum_o = rc_bits_q;
    assign rc_sat_o           = rc_sat_q;

endmodule
